// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: forwarding mux, immediate sign-extension, destination select and load-use stall.
// Optional stall counter output enabled by defining IDEX_STALL_CNT_EN.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dinstOut,
    input  logic              wreg,
    input  logic              m2reg,
    input  logic              wmem,
    input  logic              aluimm,
    input  logic              regrt,
    input  logic [3:0]        aluc,
    input  logic [1:0]        fwda,
    input  logic [1:0]        fwdb,
    input  logic [DATA_W-1:0] qa,
    input  logic [DATA_W-1:0] qb,
    input  logic [DATA_W-1:0] ealu_fwd,
    input  logic [DATA_W-1:0] mres_fwd,
    input  logic [DATA_W-1:0] mmo_fwd,
    input  logic              flush,
    output logic              stall,
    output logic              ewreg,
    output logic              em2reg,
    output logic              ewmem,
    output logic              ealuimm,
    output logic [3:0]        ealuc,
    output logic [DATA_W-1:0] ea,
    output logic [DATA_W-1:0] eb,
    output logic [DATA_W-1:0] eimm,
    output logic [REG_AW-1:0] edestReg,
    output logic              evalid
`ifdef IDEX_STALL_CNT_EN
    ,output logic [15:0]      stall_count
`endif
);

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_MRES = 2'b01,
        FWD_EALU = 2'b10,
        FWD_MMO  = 2'b11
    } fwd_sel_e;

    logic [5:0]        opcode;
    logic [4:0]        rs, rt, rd;
    logic              rt_is_src;
    logic [DATA_W-1:0] opa, opb;
    logic              load_bubble;

    logic              ewreg_q, em2reg_q, ewmem_q, ealuimm_q, evalid_q;
    logic              ewreg_d, em2reg_d, ewmem_d, ealuimm_d, evalid_d;
    logic [3:0]        ealuc_q, ealuc_d;
    logic [DATA_W-1:0] ea_q, ea_d, eb_q, eb_d, eimm_q, eimm_d;
    logic [REG_AW-1:0] edest_q, edest_d;

    function automatic logic [DATA_W-1:0] fwd_mux(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rf
    );
        case (fwd_sel_e'(sel))
            FWD_MRES: fwd_mux = mres_fwd;
            FWD_EALU: fwd_mux = ealu_fwd;
            FWD_MMO:  fwd_mux = mmo_fwd;
            default:  fwd_mux = rf;
        endcase
    endfunction

    assign opcode    = dinstOut[31:26];
    assign rs        = dinstOut[25:21];
    assign rt        = dinstOut[20:16];
    assign rd        = dinstOut[15:11];
    assign rt_is_src = (opcode == 6'b000000) | wmem;
    assign opa       = fwd_mux(fwda, qa);
    assign opb       = fwd_mux(fwdb, qb);

    // A load in execute whose result a decode-stage source needs cannot be forwarded yet.
    assign stall = evalid_q & ewreg_q & em2reg_q & (edest_q != '0) &
                   ((edest_q == REG_AW'(rs)) | ((edest_q == REG_AW'(rt)) & rt_is_src));

    assign load_bubble = flush | stall;

    always_comb begin
        ewreg_d   = 1'b0;
        em2reg_d  = 1'b0;
        ewmem_d   = 1'b0;
        ealuimm_d = 1'b0;
        ealuc_d   = '0;
        ea_d      = '0;
        eb_d      = '0;
        eimm_d    = '0;
        edest_d   = '0;
        evalid_d  = 1'b0;
        if (!load_bubble) begin
            ewreg_d   = wreg;
            em2reg_d  = m2reg;
            ewmem_d   = wmem;
            ealuimm_d = aluimm;
            ealuc_d   = aluc;
            ea_d      = opa;
            eb_d      = opb;
            eimm_d    = DATA_W'({{16{dinstOut[15]}}, dinstOut[15:0]});
            edest_d   = regrt ? REG_AW'(rt) : REG_AW'(rd);
            evalid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ewreg_q   <= 1'b0;
            em2reg_q  <= 1'b0;
            ewmem_q   <= 1'b0;
            ealuimm_q <= 1'b0;
            ealuc_q   <= '0;
            ea_q      <= '0;
            eb_q      <= '0;
            eimm_q    <= '0;
            edest_q   <= '0;
            evalid_q  <= 1'b0;
        end else begin
            ewreg_q   <= ewreg_d;
            em2reg_q  <= em2reg_d;
            ewmem_q   <= ewmem_d;
            ealuimm_q <= ealuimm_d;
            ealuc_q   <= ealuc_d;
            ea_q      <= ea_d;
            eb_q      <= eb_d;
            eimm_q    <= eimm_d;
            edest_q   <= edest_d;
            evalid_q  <= evalid_d;
        end
    end

    assign ewreg    = ewreg_q;
    assign em2reg   = em2reg_q;
    assign ewmem    = ewmem_q;
    assign ealuimm  = ealuimm_q;
    assign ealuc    = ealuc_q;
    assign ea       = ea_q;
    assign eb       = eb_q;
    assign eimm     = eimm_q;
    assign edestReg = edest_q;
    assign evalid   = evalid_q;

`ifdef IDEX_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Flushed stalls are not counted: the held instruction is being discarded anyway.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !flush && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed test-plan cases plus randomized traffic against a reference model.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dinstOut;
    logic        wreg, m2reg, wmem, aluimm, regrt, flush;
    logic [3:0]  aluc;
    logic [1:0]  fwda, fwdb;
    logic [31:0] qa, qb, ealu_fwd, mres_fwd, mmo_fwd;
    logic        stall, ewreg, em2reg, ewmem, ealuimm, evalid;
    logic [3:0]  ealuc;
    logic [31:0] ea, eb, eimm;
    logic [4:0]  edestReg;
`ifdef IDEX_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .dinstOut(dinstOut),
        .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .aluimm(aluimm), .regrt(regrt),
        .aluc(aluc), .fwda(fwda), .fwdb(fwdb), .qa(qa), .qb(qb),
        .ealu_fwd(ealu_fwd), .mres_fwd(mres_fwd), .mmo_fwd(mmo_fwd), .flush(flush),
        .stall(stall), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm),
        .ealuc(ealuc), .ea(ea), .eb(eb), .eimm(eimm), .edestReg(edestReg), .evalid(evalid)
`ifdef IDEX_STALL_CNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: what execute should hold, as a record of the last accepted instruction.
    typedef struct {
        bit        valid, wr, m2r, wm, aimm;
        bit [3:0]  op;
        bit [31:0] a, b, imm;
        bit [4:0]  dest;
    } ex_t;
    ex_t         mdl;
    int unsigned mdl_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_stall();
        int rs_n = int'(dinstOut[25:21]);
        int rt_n = int'(dinstOut[20:16]);
        bit rt_used = (dinstOut[31:26] == 6'd0) || wmem;
        if (!mdl.valid || !mdl.wr || !mdl.m2r || mdl.dest == 0) return 1'b0;
        return (int'(mdl.dest) == rs_n) || (rt_used && int'(mdl.dest) == rt_n);
    endfunction

    function automatic bit [31:0] pick(input bit [1:0] sel, input bit [31:0] rf);
        if (sel == 2'd1) return mres_fwd;
        if (sel == 2'd2) return ealu_fwd;
        if (sel == 2'd3) return mmo_fwd;
        return rf;
    endfunction

    function automatic void model_clear();
        mdl = '{default: 0};
    endfunction

    function automatic void model_edge(input bit st);
        if (flush || st) begin
            model_clear();
        end else begin
            mdl.valid = 1; mdl.wr = wreg; mdl.m2r = m2reg; mdl.wm = wmem; mdl.aimm = aluimm;
            mdl.op    = aluc;
            mdl.a     = pick(fwda, qa);
            mdl.b     = pick(fwdb, qb);
            mdl.imm   = 32'(signed'(dinstOut[15:0]));
            mdl.dest  = regrt ? dinstOut[20:16] : dinstOut[15:11];
        end
        if (st && !flush && mdl_cnt < 65535) mdl_cnt++;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, ".evalid"}, 32'(evalid), 32'(mdl.valid));
        check({tag, ".ewreg"}, 32'(ewreg), 32'(mdl.wr));
        check({tag, ".em2reg"}, 32'(em2reg), 32'(mdl.m2r));
        check({tag, ".ewmem"}, 32'(ewmem), 32'(mdl.wm));
        check({tag, ".ealuimm"}, 32'(ealuimm), 32'(mdl.aimm));
        check({tag, ".ealuc"}, 32'(ealuc), 32'(mdl.op));
        check({tag, ".edest"}, 32'(edestReg), 32'(mdl.dest));
        if (mdl.valid) begin
            check({tag, ".ea"}, ea, mdl.a);
            check({tag, ".eb"}, eb, mdl.b);
            check({tag, ".eimm"}, eimm, mdl.imm);
        end
`ifdef IDEX_STALL_CNT_EN
        check({tag, ".cnt"}, 32'(stall_count), mdl_cnt);
`endif
    endtask

    // Inputs are already driven; check stall, clock once, check registered outputs.
    task automatic step(input string tag);
        bit st;
        #1;
        st = model_stall();
        check({tag, ".stall"}, 32'(stall), 32'(st));
        @(posedge clk);
        model_edge(st);
        #1;
        check_regs(tag);
    endtask

    task automatic drive(input logic [31:0] inst, input logic w, input logic m2,
                         input logic wm, input logic ai, input logic rr, input logic [3:0] op);
        dinstOut = inst; wreg = w; m2reg = m2; wmem = wm; aluimm = ai; regrt = rr; aluc = op;
    endtask

    localparam logic [31:0] ADD_3_1_2 = 32'h0022_1820;
    localparam logic [31:0] LW_4_M4_1 = 32'h8C24_FFFC;
    localparam logic [31:0] SUB_5_4_2 = 32'h0082_2822;
    localparam logic [31:0] LW_0_M4_1 = 32'h8C20_FFFC;
    localparam logic [31:0] ADD_3_0_0 = 32'h0000_1820;
    localparam logic [31:0] ADDI_4_1  = 32'h2024_0001;

    initial begin
        rst = 1'b1; flush = 1'b0; fwda = 2'd0; fwdb = 2'd0;
        qa = '0; qb = '0; ealu_fwd = 32'h1111_1111; mres_fwd = 32'h2222_2222; mmo_fwd = 32'hDEAD;
        drive(32'h0, 0, 0, 0, 0, 0, 4'd0);
        model_clear(); mdl_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.stall", 32'(stall), 32'd0);
        check_regs("reset");
        rst = 1'b0;

        // ADD $3,$1,$2
        qa = 32'd5; qb = 32'd7;
        drive(ADD_3_1_2, 1, 0, 0, 0, 0, 4'b0010);
        step("add");
        check("add.ea_const", ea, 32'd5);
        check("add.dest_const", 32'(edestReg), 32'd3);

        // Asynchronous reset while an instruction sits in execute
        #2 rst = 1'b1;
        #1;
        model_clear(); mdl_cnt = 0;
        check("arst.ewreg", 32'(ewreg), 32'd0);
        check("arst.stall", 32'(stall), 32'd0);
        check_regs("arst");
        @(negedge clk) rst = 1'b0;

        // LW $4,-4($1)
        drive(LW_4_M4_1, 1, 1, 0, 1, 1, 4'b0010);
        step("lw");
        check("lw.eimm_const", eimm, 32'hFFFF_FFFC);

        // Dependent SUB: one stall, then forwarded from memory read data
        drive(SUB_5_4_2, 1, 0, 0, 0, 0, 4'b0110);
        step("lu1");
        check("lu1.evalid_const", 32'(evalid), 32'd0);
        fwda = 2'b11;
        step("lu2");
        check("lu2.ea_const", ea, 32'hDEAD);
        fwda = 2'b00;

        // LW $0 then consumer of $0
        drive(LW_0_M4_1, 1, 1, 0, 1, 1, 4'b0010);
        step("lw0");
        drive(ADD_3_0_0, 1, 0, 0, 0, 0, 4'b0010);
        step("use0");

        // LW $4 then ADDI writing $4
        drive(LW_4_M4_1, 1, 1, 0, 1, 1, 4'b0010);
        step("lw4b");
        drive(ADDI_4_1, 1, 0, 0, 1, 1, 4'b0010);
        step("addi");

        // Flush coinciding with a would-be stall
        drive(LW_4_M4_1, 1, 1, 0, 1, 1, 4'b0010);
        step("lw4c");
        drive(SUB_5_4_2, 1, 0, 0, 0, 0, 4'b0110);
        flush = 1'b1;
        step("flst");
        flush = 1'b0;

        // Randomized traffic with narrow register fields to provoke hazards
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r = $urandom;
            r[25:21] = 5'($urandom_range(0, 3));
            r[20:16] = 5'($urandom_range(0, 3));
            r[15:11] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) r[31:26] = 6'd0;
            dinstOut = r;
            wreg = 1'($urandom); m2reg = 1'($urandom); wmem = 1'($urandom);
            aluimm = 1'($urandom); regrt = 1'($urandom); aluc = 4'($urandom);
            fwda = 2'($urandom); fwdb = 2'($urandom);
            qa = $urandom; qb = $urandom; ealu_fwd = $urandom; mres_fwd = $urandom; mmo_fwd = $urandom;
            flush = ($urandom_range(0, 7) == 0);
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Decode-to-execute pipeline register of the 5-stage MIPS core. It sits directly downstream of the decode control unit and does the following:
- latches that unit's control word and applies its forwarding selects to the register-file operands;
- sign-extends the immediate and resolves the destination register;
- presents everything to the execute stage one cycle later.

It also detects the load-use hazard that forwarding cannot cover. On a hazard it stalls fetch/decode and injects a bubble into execute.

## Interface
Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- dinstOut  in  32  decode-stage instruction
- wreg, m2reg, wmem, aluimm, regrt  in  1  decode control bits
- aluc  in  4  ALU operation code
- fwda, fwdb  in  2  operand source select: 00 regfile, 01 mem-stage result, 10 execute ALU result, 11 memory read data
- qa, qb  in  DATA_W  register-file read data (rs, rt)
- ealu_fwd, mres_fwd, mmo_fwd  in  DATA_W  forwarded values for selects 10, 01, 11
- flush  in  1  kill the decode-stage instruction (taken branch/jump)
- stall  out  1  combinational; holds PC and IF/ID
- ewreg, em2reg, ewmem, ealuimm  out  1  registered control
- ealuc  out  4  registered ALU code
- ea, eb  out  DATA_W  registered operands after forwarding
- eimm  out  DATA_W  registered sign-extended immediate
- edestReg  out  REG_AW  registered destination register
- evalid  out  1  execute stage holds a real instruction
- stall_count  out  16  only with IDEX_STALL_CNT_EN

## Operation
- rs = dinstOut[25:21], rt = dinstOut[20:16], rd = dinstOut[15:11].
- Destination: dest = regrt ? rt : rd.
- Immediate: eimm = {{16{dinstOut[15]}}, dinstOut[15:0]}.
- Operand mux:
  - ea selects among qa, mres_fwd, ealu_fwd, mmo_fwd per fwda.
  - eb selects the same way per fwdb, starting from qb.
  - The mux is applied before the register.
- rt is a source when the opcode is 6'b000000 (R-type) or wmem = 1 (store).
- Load-use hazard: stall = evalid & ewreg & em2reg & (edestReg != 0) & ((edestReg == rs) | (edestReg == rt & rt_is_source)).
- Priority at each clock edge (rst asynchronous, highest):
  1. flush=1: load a bubble.
  2. stall=1: load a bubble.
  3. Otherwise: load the decode values with evalid=1.
- Bubble:
  - ewreg, em2reg, ewmem, ealuimm = 0, ealuc = 0, edestReg = 0, evalid = 0.
  - ea/eb/eimm are don't-care; implementations load 0.
- stall is not gated by flush. Upstream gives flush priority over stall for PC update.
- Register 0 is never a hazard source, and writes to it are harmless downstream.
- A bubble never causes a stall, because evalid = 0.

## Timing
- Reset: every registered output = 0, stall = 0, stall_count = 0.
  - Reset takes effect immediately on assertion, mid-instruction included.
  - First capture happens on the first rising edge after deassertion.
- Latency: decode inputs appear on the e* outputs 1 cycle later.
- stall is purely combinational from dinstOut and the e* registers, valid in the same cycle.
- A load followed by a dependent instruction produces exactly one stall cycle. In the next cycle evalid = 0, so stall drops and the held instruction enters execute with forwarding select 11.
- Back-to-back loads into the same register behave the same way: one stall per dependent consumer.

## Configuration
- IDEX_STALL_CNT_EN defined:
  - stall_count increments on every edge where stall = 1 and flush = 0.
  - It saturates at 16'hFFFF and clears only on rst.
- Undefined: no stall_count port and no counter logic. Otherwise behaviour is identical.

## Test plan
- Reset mid-operation: assert rst while ewreg = 1 -> all outputs 0 asynchronously, stall = 0.
- ADD $3,$1,$2 with qa = 5, qb = 7, fwd = 00 -> next cycle: ea = 5, eb = 7, edestReg = 3, ealuc = 0010, ewreg = 1, evalid = 1.
- LW $4,-4($1) (imm 16'hFFFC, regrt = 1) -> eimm = 32'hFFFFFFFC, edestReg = 4, em2reg = 1, ealuimm = 1.
- Load-use: LW $4 in execute, then SUB $5,$4,$2 in decode:
  - stall = 1 for one cycle, and execute gets a bubble (evalid = 0, ewreg = 0).
  - Next cycle stall = 0, and SUB is latched with fwda = 11 taking mmo_fwd = 32'hDEAD.
  - With IDEX_STALL_CNT_EN, stall_count = 1.
- Non-hazards: LW $0 followed by a consumer of $0, and LW $4 followed by ADDI using $4 only as rt destination -> stall = 0.
- flush = 1 together with a would-be stall -> bubble loaded, and stall_count does not increment.
